temp_1wire_slave: RTL and testbench

1-Wire responder that emulates a DS18B20-class temperature sensor on an open-drain bus, the far end of the `temp_1wire` master. It detects reset pulses, answers with a presence pulse, and decodes Skip ROM (0xCC), Convert T (0x44) and Read Scratchpad (0xBE). It serves a 9-byte scratchpad with on-the-fly Dallas CRC-8. It sits in the master's loopback bench, or in a board-level sensor emulator fed by a temperature source.

---
 rtl/temp_1wire_slave.sv | 173 +++++++++++++++++
 tb/tb_temp_1wire_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_1wire_slave.sv
// temp_1wire_slave: DS18B20-style 1-Wire responder on an open-drain bus.
// Supports Skip ROM, Convert T and Read Scratchpad with bit-serial CRC-8.
module temp_1wire_slave #(
    parameter int CLK_US       = 125,
    parameter int RST_MIN_US   = 400,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_US      = 120,
    parameter int SAMPLE_US    = 30,
    parameter int HOLD_US      = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [15:0] t_data,
    output logic        conv_req,
    output logic        rd_act
);
    localparam logic [15:0] RST_CYC  = 16'(RST_MIN_US * CLK_US);
    // Sync and edge detect have already used three cycles of the wait.
    localparam logic [15:0] WAIT_END = 16'(PRES_WAIT_US * CLK_US - 3);
    localparam logic [15:0] PRES_END = 16'(PRES_US * CLK_US - 1);
    localparam logic [15:0] SMP_END  = 16'(SAMPLE_US * CLK_US - 1);
    localparam logic [15:0] HOLD_END = 16'(HOLD_US * CLK_US - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_PRES, PRES, ROM_CMD, FUNC_CMD, TX, HALT
    } state_t;

    state_t      state, nxt;
    logic        dq_s1, dq_s2, dq_prev;
    logic [15:0] low_cnt;
    logic [15:0] tmr;
    logic        slot_act;
    logic [6:0]  bit_cnt;
    logic [6:0]  sh;
    logic [15:0] snap;
    logic [7:0]  crc;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        fall, rise, bus_rst;
    logic        cmd_st, timed, slot_end, byte_done, tx_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_s1   <= 1'b1;
            dq_s2   <= 1'b1;
            dq_prev <= 1'b1;
        end else begin
            dq_s1   <= dq_in;
            dq_s2   <= dq_s1;
            dq_prev <= dq_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            low_cnt <= '0;
        else if (dq_s2)
            low_cnt <= '0;
        else if (low_cnt != RST_CYC)
            low_cnt <= low_cnt + 16'd1;
    end

    assign fall      = dq_prev & ~dq_s2;
    assign rise      = ~dq_prev & dq_s2;
    assign bus_rst   = rise && (low_cnt == RST_CYC);
    assign cmd_st    = (state == ROM_CMD) || (state == FUNC_CMD);
    assign timed     = (state == WAIT_PRES) || (state == PRES);
    assign slot_end  = slot_act &&
                       (tmr == ((state == TX) ? HOLD_END : SMP_END));
    assign byte_done = cmd_st && slot_end && (bit_cnt[2:0] == 3'd7);
    assign rx_byte   = {dq_s2, sh};

    always_comb begin
        tx_byte = crc;
        case (bit_cnt[6:3])
            4'd0:    tx_byte = snap[7:0];
            4'd1:    tx_byte = snap[15:8];
            4'd2:    tx_byte = 8'h4B;
            4'd3:    tx_byte = 8'h46;
            4'd4:    tx_byte = 8'h7F;
            4'd5:    tx_byte = 8'hFF;
            4'd6:    tx_byte = 8'h0C;
            4'd7:    tx_byte = 8'h10;
            default: tx_byte = crc;
        endcase
    end

    assign tx_bit = tx_byte[bit_cnt[2:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt    = state;
        dq_oe  = 1'b0;
        rd_act = 1'b0;
        if (bus_rst) begin
            nxt = WAIT_PRES;
        end else begin
            unique case (state)
                IDLE, HALT: nxt = state;
                WAIT_PRES:
                    if (tmr == WAIT_END) nxt = PRES;
                PRES:
                    if (tmr == PRES_END) nxt = ROM_CMD;
                ROM_CMD:
                    if (byte_done)
                        nxt = (rx_byte == 8'hCC) ? FUNC_CMD : HALT;
                FUNC_CMD:
                    if (byte_done)
                        nxt = (rx_byte == 8'hBE) ? TX : HALT;
                TX:
                    if (slot_end && bit_cnt == 7'd71) nxt = HALT;
                default: nxt = IDLE;
            endcase
        end
        if (state == PRES)
            dq_oe = 1'b1;
        if (state == TX) begin
            rd_act = 1'b1;
            dq_oe  = slot_act & ~tx_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr      <= '0;
            slot_act <= 1'b0;
            bit_cnt  <= '0;
            sh       <= '0;
            snap     <= '0;
            crc      <= '0;
            conv_req <= 1'b0;
        end else begin
            conv_req <= 1'b0;
            if (bus_rst) begin
                tmr      <= '0;
                slot_act <= 1'b0;
                bit_cnt  <= '0;
            end else if (timed) begin
                tmr <= (nxt != state) ? 16'd0 : tmr + 16'd1;
            end else if (slot_act) begin
                tmr <= tmr + 16'd1;
                if (slot_end) begin
                    slot_act <= 1'b0;
                    bit_cnt  <= byte_done ? 7'd0 : bit_cnt + 7'd1;
                    if (cmd_st)
                        sh <= rx_byte[7:1];
                    if (state == TX && !bit_cnt[6])
                        crc <= {1'b0, crc[7:1]} ^
                               ((crc[0] ^ tx_bit) ? 8'h8C : 8'h00);
                    if (byte_done && state == FUNC_CMD) begin
                        if (rx_byte == 8'hBE) begin
                            snap <= t_data;
                            crc  <= '0;
                        end
                        if (rx_byte == 8'h44)
                            conv_req <= 1'b1;
                    end
                end
            end else if (fall && (cmd_st || state == TX)) begin
                tmr      <= '0;
                slot_act <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_temp_1wire_slave.sv
// tb_temp_1wire_slave: bus-master stimulus queues expected events;
// a negedge monitor checks presence, conv_req and read-back bytes.
`timescale 1ns/1ps
module tb_temp_1wire_slave;
    localparam int CLK_US       = 1;
    localparam int RST_MIN_US   = 400;
    localparam int PRES_WAIT_US = 30;
    localparam int PRES_US      = 120;
    localparam int SAMPLE_US    = 30;
    localparam int HOLD_US      = 30;
    localparam int EV_PRES = 0;
    localparam int EV_CONV = 1;
    localparam int EV_BYTE = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_low;
    logic        dq_in;
    logic        dq_oe;
    logic [15:0] t_data;
    logic        conv_req;
    logic        rd_act;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  rel_cyc  = 0;
    bit  rd_mode  = 1'b0;
    ev_t exq[$];

    bit         oe_q = 1'b0, conv_q = 1'b0, mlow_q = 1'b0;
    bit         pulse_rd = 1'b0, armed = 1'b0;
    int         plen = 0, pstart = 0, rcnt = 0, nb = 0;
    logic [7:0] rbyte = 8'h00;

    logic [7:0]  r_rom, r_fn;
    logic [15:0] r_td;

    temp_1wire_slave #(
        .CLK_US(CLK_US), .RST_MIN_US(RST_MIN_US),
        .PRES_WAIT_US(PRES_WAIT_US), .PRES_US(PRES_US),
        .SAMPLE_US(SAMPLE_US), .HOLD_US(HOLD_US)
    ) dut (
        .clk(clk), .rst(rst), .dq_in(dq_in), .dq_oe(dq_oe),
        .t_data(t_data), .conv_req(conv_req), .rd_act(rd_act)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign dq_in = ~(m_low | dq_oe);

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exq.push_back(e);
    endtask

    task automatic pop_ev(input int k, input logic [7:0] v, input string nm);
        ev_t e;
        if (exq.size() == 0) begin
            chk(1'b0, {nm, "_unexpected"}, k * 256 + v, -1);
            return;
        end
        e = exq.pop_front();
        chk(e.kind == k && (k != EV_BYTE || e.val == v), nm,
            k * 256 + v, e.kind * 256 + e.val);
    endtask

    // Reference scratchpad: two temperature bytes, fixed config, CRC-8.
    function automatic logic [7:0] fixed_byte(input logic [15:0] td,
                                              input int i);
        case (i)
            0: return td[7:0];
            1: return td[15:8];
            2: return 8'h4B;
            3: return 8'h46;
            4: return 8'h7F;
            5: return 8'hFF;
            6: return 8'h0C;
            default: return 8'h10;
        endcase
    endfunction

    function automatic logic [7:0] pad_byte(input logic [15:0] td,
                                            input int i);
        logic [7:0] c, b;
        bit mix;
        if (i < 8) return fixed_byte(td, i);
        c = 8'h00;
        for (int j = 0; j < 8; j++) begin
            b = fixed_byte(td, j);
            for (int k = 0; k < 8; k++) begin
                mix = c[0] ^ b[0];
                c = c >> 1;
                if (mix) c = c ^ 8'h8C;
                b = b >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] rand_other();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255));
        while (v == 8'hCC || v == 8'h44 || v == 8'hBE);
        return v;
    endfunction

    task automatic wait_us(input int n);
        repeat (n * CLK_US) @(posedge clk);
        #1;
    endtask

    task automatic bus_low(input int us);
        if (us >= RST_MIN_US) push_ev(EV_PRES, 8'h00);
        m_low = 1'b1;
        wait_us(us);
        m_low = 1'b0;
        rel_cyc = cyc;
        wait_us(200);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1;
            wait_us(v[i] ? 6 : 60);
            m_low = 1'b0;
            wait_us(v[i] ? 59 : 5);
        end
    endtask

    task automatic read_slot();
        m_low = 1'b1;
        wait_us(4);
        m_low = 1'b0;
        wait_us(61);
    endtask

    task automatic run_txn(input logic [7:0] rom, input logic [7:0] fn,
                           input logic [15:0] td, input bit chg,
                           input logic [15:0] td2);
        bit scr;
        int nbytes;
        scr = (rom == 8'hCC) && (fn == 8'hBE);
        t_data = td;
        bus_low(480);
        if (rom == 8'hCC && fn == 8'h44) push_ev(EV_CONV, 8'h00);
        write_byte(rom);
        if (rom == 8'hCC) write_byte(fn);
        nbytes = scr ? 9 : 1;
        for (int i = 0; i < nbytes; i++)
            push_ev(EV_BYTE, scr ? pad_byte(td, i) : 8'hFF);
        rd_mode = 1'b1;
        for (int s = 0; s < nbytes * 8; s++) begin
            if (scr) chk(rd_act == 1'b1, "rd_act_tx", rd_act, 1);
            read_slot();
            if (chg && s == 0) t_data = td2;
        end
        rd_mode = 1'b0;
        chk(rd_act == 1'b0, "rd_act_after", rd_act, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (conv_req) begin
                if (conv_q) chk(1'b0, "conv_width", 2, 1);
                else pop_ev(EV_CONV, 8'h00, "conv");
            end
            if (dq_oe && !oe_q) begin
                plen = 1;
                pstart = cyc;
                pulse_rd = rd_act;
            end else if (dq_oe) begin
                plen++;
            end else if (oe_q && !pulse_rd && rst) begin
                pop_ev(EV_PRES, 8'h00, "presence");
                chk((pstart - rel_cyc) >= PRES_WAIT_US * CLK_US - 2 &&
                    (pstart - rel_cyc) <= PRES_WAIT_US * CLK_US + 2,
                    "pres_delay", pstart - rel_cyc, PRES_WAIT_US * CLK_US);
                chk(plen == PRES_US * CLK_US, "pres_len",
                    plen, PRES_US * CLK_US);
            end
            if (!rd_mode) begin
                armed = 1'b0;
                nb = 0;
            end else if (m_low && !mlow_q) begin
                armed = 1'b1;
                rcnt = 0;
            end else if (armed) begin
                rcnt++;
                if (rcnt == 15 * CLK_US) begin
                    armed = 1'b0;
                    rbyte[nb] = dq_in;
                    nb++;
                    if (nb == 8) begin
                        pop_ev(EV_BYTE, rbyte, "rd_byte");
                        nb = 0;
                    end
                end
            end
            oe_q = dq_oe;
            conv_q = conv_req;
            mlow_q = m_low;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m_low = 1'b0;
        t_data = 16'h0000;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk(dq_oe == 1'b0, "rst_dq_oe", dq_oe, 0);
        chk(conv_req == 1'b0, "rst_conv_req", conv_req, 0);
        chk(rd_act == 1'b0, "rst_rd_act", rd_act, 0);

        bus_low(300);
        chk(dq_oe == 1'b0, "short_low_oe", dq_oe, 0);
        chk(rd_act == 1'b0, "short_low_rd_act", rd_act, 0);

        run_txn(8'hCC, 8'h44, 16'h0550, 1'b0, 16'h0000);
        run_txn(8'hCC, 8'hBE, 16'h0550, 1'b1, 16'h0191);
        run_txn(8'h33, 8'h00, 16'h0550, 1'b0, 16'h0000);

        for (int n = 0; n < 3; n++) begin
            r_td = 16'($urandom);
            r_rom = ($urandom_range(0, 3) == 0) ? rand_other() : 8'hCC;
            case ($urandom_range(0, 3))
                0: r_fn = 8'h44;
                3: r_fn = rand_other();
                default: r_fn = 8'hBE;
            endcase
            run_txn(r_rom, r_fn, r_td, 1'($urandom_range(0, 1)),
                    16'($urandom));
        end

        t_data = 16'($urandom) & 16'hFFFE;
        bus_low(480);
        write_byte(8'hCC);
        write_byte(8'hBE);
        m_low = 1'b1;
        wait_us(10);
        chk(dq_oe == 1'b1, "abort_drive0", dq_oe, 1);
        wait_us(470);
        chk(dq_oe == 1'b0, "abort_released", dq_oe, 0);
        push_ev(EV_PRES, 8'h00);
        m_low = 1'b0;
        rel_cyc = cyc;
        wait_us(5);
        chk(rd_act == 1'b0, "abort_rd_act", rd_act, 0);
        wait_us(200);

        m_low = 1'b1;
        wait_us(480);
        m_low = 1'b0;
        rel_cyc = cyc;
        wait_us(60);
        chk(dq_oe == 1'b1, "pres_before_rst", dq_oe, 1);
        rst = 1'b0;
        #1;
        chk(dq_oe == 1'b0, "rst_async_oe", dq_oe, 0);
        wait_us(5);
        rst = 1'b1;
        wait_us(200);

        bus_low(480);
        wait_us(20);
        chk(exq.size() == 0, "queue_empty", exq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
